// File: rtl/core_xreg_sb.sv
// core_xreg_sb: parametrised register file with write-through bypass and per-register busy scoreboard.
module core_xreg_sb #(
  parameter int DATA_W   = 32,
  parameter int NUM_REGS = 32,
  parameter int ADDR_W   = $clog2(NUM_REGS),
  parameter int RD_PORTS = 2,
  parameter int ZERO_REG = 1
) (
  input  logic                         clk_i,
  input  logic                         rst_n_i,
  input  logic [RD_PORTS*ADDR_W-1:0]   raddr_i,
  output logic [RD_PORTS*DATA_W-1:0]   rdata_o,
  output logic [RD_PORTS-1:0]          rbusy_o,
  input  logic                         wb0_vld_i,
  input  logic [ADDR_W-1:0]            wb0_addr_i,
  input  logic [DATA_W-1:0]            wb0_data_i,
  input  logic                         wb1_vld_i,
  input  logic [ADDR_W-1:0]            wb1_addr_i,
  input  logic [DATA_W-1:0]            wb1_data_i,
  input  logic                         issue_vld_i,
  input  logic [ADDR_W-1:0]            issue_addr_i,
  input  logic                         flush_i,
  output logic                         sb_idle_o
);
  localparam logic [ADDR_W:0] LP_N = (ADDR_W+1)'(NUM_REGS);

  function automatic logic f_ok(input logic [ADDR_W-1:0] a);
    return ({1'b0, a} < LP_N) && !((ZERO_REG != 0) && (a == '0));
  endfunction

  logic [DATA_W-1:0]   r_regs [NUM_REGS];
  logic [NUM_REGS-1:0] r_busy;
  logic                r_idle;
  logic [NUM_REGS-1:0] w_busy_nxt;
  logic                w_wb0_ok, w_wb1_ok, w_iss_ok;

  assign w_wb0_ok  = wb0_vld_i && f_ok(wb0_addr_i);
  assign w_wb1_ok  = wb1_vld_i && f_ok(wb1_addr_i);
  assign w_iss_ok  = issue_vld_i && f_ok(issue_addr_i);
  assign sb_idle_o = r_idle;

  // Flush beats issue, issue beats a same-cycle writeback to the same register.
  always_comb begin
    w_busy_nxt = r_busy;
    for (int r = 0; r < NUM_REGS; r++)
      w_busy_nxt[r] = flush_i ? 1'b0
                    : (w_iss_ok && issue_addr_i == ADDR_W'(r)) ? 1'b1
                    : ((w_wb0_ok && wb0_addr_i == ADDR_W'(r)) ||
                       (w_wb1_ok && wb1_addr_i == ADDR_W'(r))) ? 1'b0
                    : r_busy[r];
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_regs <= '{default: '0};
      r_busy <= '0;
      r_idle <= 1'b1;
    end else begin
      for (int r = 0; r < NUM_REGS; r++)
        if (w_wb1_ok && wb1_addr_i == ADDR_W'(r)) r_regs[r] <= wb1_data_i;
        else if (w_wb0_ok && wb0_addr_i == ADDR_W'(r)) r_regs[r] <= wb0_data_i;
      r_busy <= w_busy_nxt;
      r_idle <= ~|w_busy_nxt;
    end
  end

  for (genvar k = 0; k < RD_PORTS; k++) begin : g_rd
    logic [ADDR_W-1:0] w_ra, w_ix;
    logic              w_ok, w_h0, w_h1;
    assign w_ra = raddr_i[k*ADDR_W +: ADDR_W];
    assign w_ok = f_ok(w_ra);
    assign w_ix = w_ok ? w_ra : '0;
    assign w_h0 = wb0_vld_i && wb0_addr_i == w_ra;
    assign w_h1 = wb1_vld_i && wb1_addr_i == w_ra;
    assign rdata_o[k*DATA_W +: DATA_W] = !w_ok ? '0 : w_h1 ? wb1_data_i : w_h0 ? wb0_data_i : r_regs[w_ix];
    assign rbusy_o[k] = w_ok && r_busy[w_ix] && !(w_h0 || w_h1);
  end
endmodule

// File: tb/tb_core_xreg_sb.sv
// tb_core_xreg_sb: directed checks of a default instance and a 24-register 3-port instance.
module tb_core_xreg_sb;
  logic clk = 1'b0, rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [9:0]  ra;
  logic [63:0] rd;
  logic [1:0]  rb;
  logic        w0v, w1v, iv, fl, idle;
  logic [4:0]  w0a, w1a, ia;
  logic [31:0] w0d, w1d;

  logic [14:0] b_ra;
  logic [95:0] b_rd;
  logic [2:0]  b_rb;
  logic        b_w0v, b_w1v, b_iv, b_fl, b_idle;
  logic [4:0]  b_w0a, b_w1a, b_ia;
  logic [31:0] b_w0d, b_w1d;

  int n_chk = 0, n_pass = 0, n_fail = 0;

  core_xreg_sb dut_a (
    .clk_i(clk), .rst_n_i(rst_n), .raddr_i(ra), .rdata_o(rd), .rbusy_o(rb),
    .wb0_vld_i(w0v), .wb0_addr_i(w0a), .wb0_data_i(w0d),
    .wb1_vld_i(w1v), .wb1_addr_i(w1a), .wb1_data_i(w1d),
    .issue_vld_i(iv), .issue_addr_i(ia), .flush_i(fl), .sb_idle_o(idle)
  );

  core_xreg_sb #(.NUM_REGS(24), .RD_PORTS(3)) dut_b (
    .clk_i(clk), .rst_n_i(rst_n), .raddr_i(b_ra), .rdata_o(b_rd), .rbusy_o(b_rb),
    .wb0_vld_i(b_w0v), .wb0_addr_i(b_w0a), .wb0_data_i(b_w0d),
    .wb1_vld_i(b_w1v), .wb1_addr_i(b_w1a), .wb1_data_i(b_w1d),
    .issue_vld_i(b_iv), .issue_addr_i(b_ia), .flush_i(b_fl), .sb_idle_o(b_idle)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  initial begin
    ra = '0; w0v = 0; w1v = 0; iv = 0; fl = 0; w0a = '0; w1a = '0; ia = '0; w0d = '0; w1d = '0;
    b_ra = '0; b_w0v = 0; b_w1v = 0; b_iv = 0; b_fl = 0; b_w0a = '0; b_w1a = '0; b_ia = '0;
    b_w0d = '0; b_w1d = '0;
    #22 rst_n = 1'b1;
    step;
    check("reset_idle", 32'(idle), 32'd1);
    for (int a = 0; a < 32; a++) begin
      ra = {5'(a), 5'(a)};
      #1;
      check($sformatf("reset_rd0_r%0d", a), rd[31:0], 32'h0);
      check($sformatf("reset_rd1_r%0d", a), rd[63:32], 32'h0);
      check($sformatf("reset_rb_r%0d", a), 32'(rb), 32'h0);
    end
    // r0 is hardwired
    ra = '0; w0v = 1; w0a = 5'd0; w0d = 32'hDEADBEEF; #1;
    check("r0_bypass", rd[31:0], 32'h0);
    step; w0v = 0; #1;
    check("r0_stored", rd[31:0], 32'h0);
    check("r0_busy", 32'(rb[0]), 32'h0);
    // dual write same address: wb1 wins
    ra = {5'd6, 5'd5}; w0v = 1; w0a = 5'd5; w0d = 32'h11; w1v = 1; w1a = 5'd5; w1d = 32'h22; #1;
    check("r5_bypass_wb1", rd[31:0], 32'h22);
    step; w0v = 0; w1v = 0; #1;
    check("r5_stored_wb1", rd[31:0], 32'h22);
    w0v = 1; w0a = 5'd6; w0d = 32'h33; #1;
    check("r6_bypass_wb0", rd[63:32], 32'h33);
    step; w0v = 0; #1;
    check("r6_stored", rd[63:32], 32'h33);
    // issue r7, writeback three cycles later
    ra = {5'd0, 5'd7}; iv = 1; ia = 5'd7; #1;
    check("r7_busy_T", 32'(rb[0]), 32'h0);
    step; iv = 0; #1;
    check("r7_busy_T1", 32'(rb[0]), 32'h1);
    check("idle_T1", 32'(idle), 32'h0);
    step;
    check("r7_busy_T2", 32'(rb[0]), 32'h1);
    step;
    check("r7_busy_T3_pre", 32'(rb[0]), 32'h1);
    w1v = 1; w1a = 5'd7; w1d = 32'h44; #1;
    check("r7_release_T3", 32'(rb[0]), 32'h0);
    check("r7_bypass_T3", rd[31:0], 32'h44);
    check("idle_T3", 32'(idle), 32'h0);
    step; w1v = 0; #1;
    check("idle_T4", 32'(idle), 32'h1);
    check("r7_busy_T4", 32'(rb[0]), 32'h0);
    check("r7_stored", rd[31:0], 32'h44);
    // issue beats writeback on the same register
    ra = {5'd0, 5'd9}; iv = 1; ia = 5'd9; step;
    w0v = 1; w0a = 5'd9; w0d = 32'h55; #1;
    check("r9_bypass", rd[31:0], 32'h55);
    check("r9_release_comb", 32'(rb[0]), 32'h0);
    step; iv = 0; w0v = 0; #1;
    check("r9_stored", rd[31:0], 32'h55);
    check("r9_still_busy", 32'(rb[0]), 32'h1);
    check("r9_idle", 32'(idle), 32'h0);
    w0v = 1; step; w0v = 0; #1;
    check("r9_cleared_idle", 32'(idle), 32'h1);
    // flush drops all marks and a same-cycle issue
    iv = 1; ia = 5'd3; step; ia = 5'd4; step; ia = 5'd8; step; iv = 0;
    ra = {5'd4, 5'd3}; #1;
    check("r3_busy", 32'(rb[0]), 32'h1);
    check("r4_busy", 32'(rb[1]), 32'h1);
    check("idle_pre_flush", 32'(idle), 32'h0);
    fl = 1; iv = 1; ia = 5'd10;
    step; fl = 0; iv = 0; #1;
    check("r3_flushed", 32'(rb[0]), 32'h0);
    check("r4_flushed", 32'(rb[1]), 32'h0);
    ra = {5'd10, 5'd8}; #1;
    check("r8_flushed", 32'(rb[0]), 32'h0);
    check("r10_not_busy", 32'(rb[1]), 32'h0);
    check("idle_post_flush", 32'(idle), 32'h1);
    // 24-register instance: address 28 is out of range
    b_ra = {5'd28, 5'd28, 5'd28};
    b_w0v = 1; b_w0a = 5'd28; b_w0d = 32'h99; b_iv = 1; b_ia = 5'd28; #1;
    for (int k = 0; k < 3; k++) check($sformatf("b_r28_bypass_p%0d", k), b_rd[k*32 +: 32], 32'h0);
    check("b_r28_busy_comb", 32'(b_rb), 32'h0);
    step; b_w0v = 0; b_iv = 0; #1;
    for (int k = 0; k < 3; k++) check($sformatf("b_r28_stored_p%0d", k), b_rd[k*32 +: 32], 32'h0);
    check("b_r28_busy", 32'(b_rb), 32'h0);
    check("b_idle_r28", 32'(b_idle), 32'h1);
    b_w1v = 1; b_w1a = 5'd20; b_w1d = 32'hAB; b_iv = 1; b_ia = 5'd21;
    step; b_w1v = 0; b_iv = 0;
    b_ra = {5'd20, 5'd21, 5'd28}; #1;
    check("b_r20_stored", b_rd[95:64], 32'hAB);
    check("b_r21_busy", 32'(b_rb[1]), 32'h1);
    check("b_idle_busy", 32'(b_idle), 32'h0);
    ra = {5'd6, 5'd5};
    // asynchronous reset mid-operation
    rst_n = 1'b0; #1;
    check("b_rst_r20", b_rd[95:64], 32'h0);
    check("b_rst_busy", 32'(b_rb), 32'h0);
    check("b_rst_idle", 32'(b_idle), 32'h1);
    check("a_rst_r5", rd[31:0], 32'h0);
    check("a_rst_r6", rd[63:32], 32'h0);
    #10 rst_n = 1'b1;
    step;
    check("a_post_rst_r5", rd[31:0], 32'h0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/core_xreg_sb.md
# core_xreg_sb

Parametrised integer register file with a per-register busy scoreboard, successor to the fixed 32x32, 2-read/1-write register file. Sits between decode/issue and the two writeback paths (ALU and LSU): provides N read ports with same-cycle write-through bypass, two prioritised write ports, and busy tracking so issue can stall on registers with a pending multi-cycle writeback. Also supports a pipeline flush that drops all pending busy marks.

## Interface
- DATA_W, 32, register width in bits
- NUM_REGS, 32, number of architectural registers (2..64)
- ADDR_W, $clog2(NUM_REGS), register address width (derived; not overridden)
- RD_PORTS, 2, number of read ports (1..4)
- ZERO_REG, 1, 1 = register 0 hardwired to zero and never busy

- clk_i  in  1  clock
- rst_n_i  in  1  reset, asynchronous, active-low
- raddr_i  in  RD_PORTS*ADDR_W  read addresses, port k at [k*ADDR_W +: ADDR_W]
- rdata_o  out  RD_PORTS*DATA_W  read data, port k at [k*DATA_W +: DATA_W]
- rbusy_o  out  RD_PORTS  port k register has an outstanding writeback
- wb0_vld_i  in  1  ALU writeback valid
- wb0_addr_i  in  ADDR_W  ALU writeback address
- wb0_data_i  in  DATA_W  ALU writeback data
- wb1_vld_i  in  1  LSU writeback valid
- wb1_addr_i  in  ADDR_W  LSU writeback address
- wb1_data_i  in  DATA_W  LSU writeback data
- issue_vld_i  in  1  instruction issued with a pending destination
- issue_addr_i  in  ADDR_W  destination register to mark busy
- flush_i  in  1  clear all busy marks
- sb_idle_o  out  1  registered: no register busy

## Operation
- Storage: NUM_REGS x DATA_W flops, busy_q[NUM_REGS-1:0]; all cleared by rst_n_i low.
- Valid address: addr < NUM_REGS and not (ZERO_REG and addr == 0). Writes/issues to invalid addresses are ignored; reads of invalid addresses return 0, rbusy 0.
- Write: on clk_i rising edge, wbN_vld_i with valid address writes wbN_data_i. Both ports same address same cycle: wb1 data stored.
- Read (combinational, per port k): if wb1 valid and wb1_addr == raddr -> wb1_data; else if wb0 valid and matching -> wb0_data; else stored value. Invalid address -> 0 regardless of bypass.
- rbusy_o[k] = busy_q[raddr] and not (any valid writeback to raddr this cycle) — writeback in the same cycle releases the dependency combinationally.
- Busy update, per register r, priority highest first:
  - flush_i -> 0 (issue in the same cycle is dropped)
  - issue_vld_i to r -> 1 (wins over a same-cycle writeback to r)
  - valid writeback (either port) to r -> 0
  - else hold
- Writebacks always update data, including during flush and regardless of busy state.
- sb_idle_o = 1 when busy_q (after update) is all zero; registered.

## Timing
- Reset values: all registers 0, busy_q 0, sb_idle_o 1, rbusy_o 0, rdata_o 0 for any address (bypass still applies if writes are driven during reset, but nothing is stored).
- Read latency 0 (combinational); written value visible via bypass in the write cycle and from storage in the following cycle.
- issue in cycle T -> rbusy_o high from T+1 until the writeback cycle (low in that cycle via release path), busy_q clear from the next edge.
- sb_idle_o reflects busy state with one cycle latency: issue at T -> sb_idle_o 0 at T+1; last writeback at T -> sb_idle_o 1 at T+1.
- Reset asserted mid-operation: storage and busy cleared immediately (asynchronous), pending writebacks lost.
- No backpressure: every input is sampled every cycle; the issuing logic owns stalling on rbusy_o.

## Test plan
- Reset, then read all addresses on every port -> rdata_o 0, rbusy_o 0, sb_idle_o 1; write 0xDEADBEEF to r0 -> r0 still reads 0, never busy.
- wb0 writes r5=0x11, wb1 writes r5=0x22 same cycle, port 0 reads r5 -> 0x22 in-cycle and next cycle; wb0 r6=0x33 alone -> bypass 0x33 same cycle.
- Issue r7 at T -> rbusy 1 at T+1..T+3, sb_idle_o 0; wb1 r7=0x44 at T+3 -> rbusy 0 and rdata 0x44 at T+3, sb_idle_o 1 at T+4.
- Issue r9 and wb0 r9=0x55 same cycle while r9 busy -> r9 = 0x55, r9 stays busy.
- Issue r3,r4,r8; flush_i with issue r10 same cycle -> all busy clear next cycle, r10 not busy, sb_idle_o 1.
- NUM_REGS=24, RD_PORTS=3: write/issue address 28 -> ignored, reads of 28 return 0 on all ports; assert rst_n_i mid-sequence -> all reads 0 same cycle.
